button_conditioner: RTL and testbench

- Front-end input stage between the board's five raw push-buttons (up/down/left/right/select) and the game FSM.
- Synchronises each asynchronous button to clk, debounces it, and emits a single-cycle press pulse per debounced press (pulse_u/d/l/r/s).
- Pulses drive avatar selection, cursor movement and piece placement downstream.
- Also exports the debounced levels for display and diagnostics.

---
 rtl/input_pkg.sv | 29 ++
 rtl/debounce_channel.sv | 128 ++++++++++++
 rtl/button_conditioner.sv | 54 +++++
 tb/tb_button_conditioner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_pkg
//  Description : Shared constants for the push-button input stage: button
//                indices, channel count and default 100 MHz timing values.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_pkg;

    // Bit positions inside btn_raw / btn_level, order {s,r,l,d,u}
    localparam int BTN_U    = 0;
    localparam int BTN_D    = 1;
    localparam int BTN_L    = 2;
    localparam int BTN_R    = 3;
    localparam int BTN_S    = 4;
    localparam int NUM_BTNS = 5;

    // Default timing at 100 MHz: 10 ms debounce, 400 ms first repeat, 100 ms repeat
    localparam int DEFAULT_DB_CYCLES     = 1_000_000;
    localparam int DEFAULT_REPEAT_DELAY  = 40_000_000;
    localparam int DEFAULT_REPEAT_PERIOD = 10_000_000;

    // Larger of two integers, used when sizing counters at elaboration
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : input_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One button channel: two-flop synchroniser, debounce counter,
//                debounced level and registered one-cycle press pulse.
//                When BTN_AUTOREPEAT_EN is defined and REPEAT_ALLOWED is 1,
//                a held button also produces auto-repeat pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import input_pkg::*;
#(
    parameter int DB_CYCLES      = DEFAULT_DB_CYCLES,
    parameter int REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD,
    parameter int REPEAT_ALLOWED = 1
) (
    input  logic clk,
    input  logic rst,       // asynchronous, active-low
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam int                c_db_w    = $clog2(DB_CYCLES);
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DB_CYCLES - 1);

    // Elaboration-time guards on the configuration
    if (DB_CYCLES < 2) begin : g_chk_db
        $error("debounce_channel: DB_CYCLES must be >= 2");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) ||
        (REPEAT_ALLOWED < 0) || (REPEAT_ALLOWED > 1)) begin : g_chk_rep
        $error("debounce_channel: illegal repeat configuration");
    end

    logic              r_meta;
    logic              r_sync;
    logic              r_level;
    logic              r_pulse;
    logic [c_db_w-1:0] r_db_cnt;
    logic              w_differ;
    logic              w_flip;
    logic              w_rise;
    logic              w_rep_hit;

    assign w_differ = (r_sync != r_level);
    assign w_flip   = w_differ && (r_db_cnt == c_db_last);
    assign w_rise   = w_flip && r_sync;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= btn_raw;
            r_sync <= r_meta;
        end
    end

    // Level flips only after DB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else if (!w_differ) begin
            r_db_cnt <= '0;
        end else if (w_flip) begin
            r_db_cnt <= '0;
            r_level  <= r_sync;
        end else begin
            r_db_cnt <= r_db_cnt + c_db_w'(1);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_ALLOWED != 0) begin : g_repeat
        localparam int c_rep_w = $clog2(max_int(max_int(REPEAT_DELAY, REPEAT_PERIOD), 2));
        localparam logic [c_rep_w-1:0] c_delay_last  = c_rep_w'(REPEAT_DELAY - 1);
        localparam logic [c_rep_w-1:0] c_period_last = c_rep_w'(REPEAT_PERIOD - 1);

        logic [c_rep_w-1:0] r_rep_cnt;
        logic               r_rep_first;
        logic               w_hold;

        // Held = level is 1 and is not falling on this edge, so the release
        // edge can never carry a repeat pulse
        assign w_hold    = r_level && !(w_flip && !r_sync);
        assign w_rep_hit = w_hold && (r_rep_first ? (r_rep_cnt == c_delay_last)
                                                  : (r_rep_cnt == c_period_last));

        // Repeat timer: idle at zero while released, counts from the press pulse
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
            end else if (!w_hold) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
            end else if (w_rep_hit) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep_cnt   <= r_rep_cnt + c_rep_w'(1);
            end
        end
    end else begin : g_no_repeat
        assign w_rep_hit = 1'b0;
    end
`else
    assign w_rep_hit = 1'b0;
`endif

    // Registered pulse: one cycle on the 0->1 level edge, plus any repeats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_rise | w_rep_hit;
        end
    end

    assign level = r_level;
    assign pulse = r_pulse;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Conditions the five raw push-buttons {s,r,l,d,u}: each is
//                synchronised, debounced and turned into a one-cycle press
//                pulse; debounced levels are exported for diagnostics.
//                Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat on
//                u/d/l/r while held; select never repeats).
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import input_pkg::*;
#(
    parameter int DB_CYCLES     = DEFAULT_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst,        // asynchronous, active-low
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic                pulse_u,
    output logic                pulse_d,
    output logic                pulse_l,
    output logic                pulse_r,
    output logic                pulse_s,
    output logic [NUM_BTNS-1:0] btn_level
);

    logic [NUM_BTNS-1:0] w_pulse;

    // Five identical, independent channels; only select is barred from repeating
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
        debounce_channel #(
            .DB_CYCLES      (DB_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_ALLOWED ((gi == BTN_S) ? 0 : 1)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[gi]),
            .level   (btn_level[gi]),
            .pulse   (w_pulse[gi])
        );
    end

    assign pulse_u = w_pulse[BTN_U];
    assign pulse_d = w_pulse[BTN_D];
    assign pulse_l = w_pulse[BTN_L];
    assign pulse_r = w_pulse[BTN_R];
    assign pulse_s = w_pulse[BTN_S];

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed self-checking bench for button_conditioner with
//                DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic       pulse_u, pulse_d, pulse_l, pulse_r, pulse_s;
    logic [4:0] btn_level;

    int checks = 0;
    int errors = 0;
    int pcnt [5];

`ifdef BTN_AUTOREPEAT_EN
    localparam bit c_rep_on = 1'b1;
`else
    localparam bit c_rep_on = 1'b0;
`endif

    always #5 clk = ~clk;

    button_conditioner #(
        .DB_CYCLES     (4),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .pulse_u   (pulse_u),
        .pulse_d   (pulse_d),
        .pulse_l   (pulse_l),
        .pulse_r   (pulse_r),
        .pulse_s   (pulse_s),
        .btn_level (btn_level)
    );

    // Pulse counters sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (pulse_u) pcnt[0]++;
        if (pulse_d) pcnt[1]++;
        if (pulse_l) pcnt[2]++;
        if (pulse_r) pcnt[3]++;
        if (pulse_s) pcnt[4]++;
    end

    function automatic logic [4:0] pv();
        return {pulse_s, pulse_r, pulse_l, pulse_d, pulse_u};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int         base [5];
        logic [4:0] vec  [2];
        int         hi   [10];
        int         lo   [10];
        vec = '{5'b11000, 5'b10010};
        hi  = '{1, 3, 2, 1, 3, 2, 1, 3, 2, 3};
        lo  = '{1, 2, 1, 2, 1, 2, 1, 1, 2, 1};

        // 1. Reset with all buttons pressed, then idle
        rst     = 1'b1;
        btn_raw = 5'b11111;
        #1 rst  = 1'b0;
        repeat (5) step();
        check("rst_level", int'(btn_level), 0);
        check("rst_pulse", int'(pv()), 0);
        btn_raw = 5'b00000;
        rst     = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            check("idle", int'({btn_level, pv()}), 0);
        end

        // 2. Clean press and release on up
        base[0] = pcnt[0];
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("press_u_pulse", int'(pulse_u), int'(k == 6));
            check("press_u_level", int'(btn_level[0]), int'(k >= 6));
        end
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("rel_u_level", int'(btn_level[0]), int'(k < 6));
            check("rel_u_pulse", int'(pulse_u), 0);
        end
        check("u_count", pcnt[0] - base[0], 1);

        // 3. Bouncing left: high phases of at most 3 cycles are rejected
        base[2] = pcnt[2];
        for (int i = 0; i < 10; i++) begin
            btn_raw[2] = 1'b1;
            repeat (hi[i]) step();
            btn_raw[2] = 1'b0;
            repeat (lo[i]) step();
        end
        check("bounce_no_pulse", pcnt[2] - base[2], 0);
        check("bounce_level", int'(btn_level[2]), 0);
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("bounce_l_pulse", int'(pulse_l), int'(k == 6));
        end
        check("l_count", pcnt[2] - base[2], 1);
        btn_raw[2] = 1'b0;
        repeat (10) step();

        // 4. Simultaneous presses give coincident single pulses
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 5; b++) base[b] = pcnt[b];
            btn_raw = vec[i];
            for (int k = 1; k <= 7; k++) begin
                step();
                check("simul_pulse", int'(pv()), (k == 6) ? int'(vec[i]) : 0);
                check("simul_level", int'(btn_level), (k >= 6) ? int'(vec[i]) : 0);
            end
            for (int b = 0; b < 5; b++)
                check("simul_count", pcnt[b] - base[b], int'(vec[i][b]));
            btn_raw = 5'b00000;
            repeat (10) step();
            check("simul_release", int'(btn_level), 0);
        end

        // 5. Reset in the middle of a debounce on down
        base[1] = pcnt[1];
        btn_raw[1] = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        check("midrst_level", int'(btn_level), 0);
        check("midrst_pulse", int'(pv()), 0);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("midrst_d_pulse", int'(pulse_d), int'(k == 6));
        end
        check("d_count", pcnt[1] - base[1], 1);
        btn_raw[1] = 1'b0;
        repeat (10) step();

        // 6. Hold up: repeats only when auto-repeat is built in
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("hold_u_press", int'(pulse_u), int'(k == 6));
        end
        for (int j = 1; j <= 62; j++) begin
            step();
            check("hold_u_repeat", int'(pulse_u),
                  int'(c_rep_on && (j >= 20) && (j <= 52) && (((j - 20) % 8) == 0)));
            check("hold_u_level", int'(btn_level[0]), int'(j < 60));
            if (j == 54) btn_raw[0] = 1'b0;
        end

        // Select never repeats
        base[4] = pcnt[4];
        btn_raw[4] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("hold_s_press", int'(pulse_s), int'(k == 6));
        end
        repeat (40) step();
        check("s_count", pcnt[4] - base[4], 1);
        btn_raw[4] = 1'b0;
        repeat (10) step();
        check("final_level", int'(btn_level), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_button_conditioner
`default_nettype wire
